// File: rtl/oled_spi_master.sv
// SPI master for SSD1306-class OLED panels: sequences the panel hardware reset,
// then serialises a valid/ready byte stream with DC selection, CS framing and bursts.
module oled_spi_master #(
    parameter int CLK_DIV    = 4,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int RST_CYCLES = 1000,
    parameter int RST_WAIT   = 1000,
    parameter int CS_IDLE    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_dc,
    input  logic       tx_last,
    input  logic       panel_reset_req,
    output logic       init_done,
    output logic       busy,
    output logic       oled_rst,
    output logic       oled_cs,
    output logic       oled_dc,
    output logic       oled_sclk,
    output logic       oled_mosi
);
    localparam int RST_MAX = (RST_CYCLES > RST_WAIT) ? RST_CYCLES : RST_WAIT;
    localparam int RST_W   = (RST_MAX > 1) ? $clog2(RST_MAX) : 1;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W   = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [RST_W-1:0] WAIT_LAST = RST_W'(RST_WAIT - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CS_IDLE - 1);

    // With CPHA=1 the first half of each bit sits at the active level, so the
    // leading edge coincides with the data change.
    localparam logic IDLE_LVL  = (CPOL != 0);
    localparam logic FIRST_LVL = IDLE_LVL ^ (CPHA != 0);

    typedef enum logic [2:0] {
        S_RST_LOW,
        S_RST_WAIT,
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             half_q, half_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             last_q, last_d;
    logic             rst_q, rst_d;
    logic             cs_q, cs_d;
    logic             dc_q, dc_d;
    logic             sclk_q, sclk_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RST_LOW;
            rst_cnt_q <= '0;
            div_cnt_q <= '0;
            gap_cnt_q <= '0;
            bit_cnt_q <= '0;
            half_q    <= 1'b0;
            shreg_q   <= '0;
            last_q    <= 1'b0;
            rst_q     <= 1'b0;
            cs_q      <= 1'b1;
            dc_q      <= 1'b0;
            sclk_q    <= IDLE_LVL;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            div_cnt_q <= div_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            half_q    <= half_d;
            shreg_q   <= shreg_d;
            last_q    <= last_d;
            rst_q     <= rst_d;
            cs_q      <= cs_d;
            dc_q      <= dc_d;
            sclk_q    <= sclk_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        div_cnt_d = div_cnt_q;
        gap_cnt_d = gap_cnt_q;
        bit_cnt_d = bit_cnt_q;
        half_d    = half_q;
        shreg_d   = shreg_q;
        last_d    = last_q;
        rst_d     = rst_q;
        cs_d      = cs_q;
        dc_d      = dc_q;
        sclk_d    = sclk_q;

        case (state_q)
            S_RST_LOW: begin
                rst_cnt_d = rst_cnt_q + 1'b1;
                if (rst_cnt_q == RST_LAST) begin
                    rst_cnt_d = '0;
                    rst_d     = 1'b1;
                    if (RST_WAIT == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RST_WAIT;
                    end
                end
            end
            S_RST_WAIT: begin
                rst_cnt_d = rst_cnt_q + 1'b1;
                if (rst_cnt_q == WAIT_LAST) begin
                    rst_cnt_d = '0;
                    state_d   = S_IDLE;
                end
            end
            S_IDLE: begin
                if (panel_reset_req) begin
                    state_d   = S_RST_LOW;
                    rst_cnt_d = '0;
                    rst_d     = 1'b0;
                    cs_d      = 1'b1;
                end else if (tx_valid) begin
                    state_d   = S_SHIFT;
                    shreg_d   = tx_data;
                    dc_d      = tx_dc;
                    last_d    = tx_last;
                    cs_d      = 1'b0;
                    sclk_d    = FIRST_LVL;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    half_d    = 1'b0;
                end
            end
            S_SHIFT: begin
                div_cnt_d = div_cnt_q + 1'b1;
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!half_q) begin
                        half_d = 1'b1;
                        sclk_d = ~FIRST_LVL;
                    end else if (bit_cnt_q == 3'd7) begin
                        // Final bit: shreg is left unshifted so mosi keeps bit 0.
                        half_d = 1'b0;
                        sclk_d = IDLE_LVL;
                        if (last_q) begin
                            cs_d      = 1'b1;
                            gap_cnt_d = '0;
                            state_d   = S_GAP;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        half_d    = 1'b0;
                        sclk_d    = FIRST_LVL;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shreg_d   = {shreg_q[6:0], 1'b0};
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_RST_LOW;
            end
        endcase
    end

    assign tx_ready  = (state_q == S_IDLE) && !panel_reset_req;
    assign init_done = (state_q == S_IDLE) || (state_q == S_SHIFT) || (state_q == S_GAP);
    assign busy      = (state_q != S_IDLE);
    assign oled_rst  = rst_q;
    assign oled_cs   = cs_q;
    assign oled_dc   = dc_q;
    assign oled_sclk = sclk_q;
    assign oled_mosi = shreg_q[7];

endmodule

// File: tb/tb_oled_spi_master.sv
// Scoreboard bench: a mode-0 and a mode-3 instance share one byte stream; monitors
// rebuild bytes from the panel pins and compare them against queued expectations.
module tb_oled_spi_master;
    localparam int CLK_DIV     = 4;
    localparam int RST_CYCLES  = 10;
    localparam int RST_WAIT    = 5;
    localparam int CS_IDLE     = 2;
    localparam int BYTE_CYCLES = 16 * CLK_DIV;
    localparam int LIMIT       = 5000;

    typedef struct packed {
        logic [7:0] data;
        logic       dc;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_dc;
    logic       tx_last;
    logic       panel_reset_req;

    // Bit 0 belongs to the CPOL=0/CPHA=0 instance, bit 1 to CPOL=1/CPHA=1.
    logic [1:0] tx_ready, init_done, busy, oled_rst, oled_cs, oled_dc, oled_sclk, oled_mosi;
    logic [1:0] idle_sclk;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];

    logic [1:0] mon_prev_sclk, mon_prev_cs, mon_dc, mon_last;
    logic [7:0] mon_bits [2];
    int         mon_cnt  [2];

    always #5 clk = ~clk;

    oled_spi_master #(
        .CLK_DIV(CLK_DIV), .CPOL(0), .CPHA(0),
        .RST_CYCLES(RST_CYCLES), .RST_WAIT(RST_WAIT), .CS_IDLE(CS_IDLE)
    ) u_dut_mode0 (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(tx_valid), .tx_ready(tx_ready[0]), .tx_data(tx_data),
        .tx_dc(tx_dc), .tx_last(tx_last), .panel_reset_req(panel_reset_req),
        .init_done(init_done[0]), .busy(busy[0]), .oled_rst(oled_rst[0]),
        .oled_cs(oled_cs[0]), .oled_dc(oled_dc[0]),
        .oled_sclk(oled_sclk[0]), .oled_mosi(oled_mosi[0])
    );

    oled_spi_master #(
        .CLK_DIV(CLK_DIV), .CPOL(1), .CPHA(1),
        .RST_CYCLES(RST_CYCLES), .RST_WAIT(RST_WAIT), .CS_IDLE(CS_IDLE)
    ) u_dut_mode3 (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(tx_valid), .tx_ready(tx_ready[1]), .tx_data(tx_data),
        .tx_dc(tx_dc), .tx_last(tx_last), .panel_reset_req(panel_reset_req),
        .init_done(init_done[1]), .busy(busy[1]), .oled_rst(oled_rst[1]),
        .oled_cs(oled_cs[1]), .oled_dc(oled_dc[1]),
        .oled_sclk(oled_sclk[1]), .oled_mosi(oled_mosi[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
        end
    endtask

    // Reference view of the bus: while CS is low both modes present a bit on each
    // rising sclk edge, MSB first; CS may only rise after a byte flagged last.
    task automatic monitorStep(input int idx, input logic sclk, input logic mosi,
                               input logic cs, input logic dc);
        exp_t e;
        int   depth;
        if (rst_n !== 1'b1) begin
            mon_cnt[idx]       = 0;
            mon_prev_sclk[idx] = idle_sclk[idx];
            mon_prev_cs[idx]   = 1'b1;
            mon_last[idx]      = 1'b0;
            return;
        end
        if (!cs && !mon_prev_sclk[idx] && sclk) begin
            if (mon_cnt[idx] == 0) mon_dc[idx] = dc;
            mon_bits[idx] = {mon_bits[idx][6:0], mosi};
            mon_cnt[idx]++;
            if (mon_cnt[idx] == 8) begin
                mon_cnt[idx] = 0;
                depth = (idx == 0) ? exp_q0.size() : exp_q1.size();
                checkOutput($sformatf("byte_expected%0d", idx), 32'(depth != 0), 32'd1);
                if (depth != 0) begin
                    e = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    checkOutput($sformatf("byte_data%0d", idx), 32'(mon_bits[idx]), 32'(e.data));
                    checkOutput($sformatf("byte_dc%0d", idx), 32'(mon_dc[idx]), 32'(e.dc));
                    mon_last[idx] = e.last;
                end
            end
        end
        if (!mon_prev_cs[idx] && cs) begin
            checkOutput($sformatf("frame_partial%0d", idx), 32'(mon_cnt[idx]), 32'd0);
            checkOutput($sformatf("frame_last%0d", idx), 32'(mon_last[idx]), 32'd1);
            checkOutput($sformatf("frame_sclk%0d", idx), 32'(sclk), 32'(idle_sclk[idx]));
        end
        mon_prev_sclk[idx] = sclk;
        mon_prev_cs[idx]   = cs;
    endtask

    always @(negedge clk) begin
        monitorStep(0, oled_sclk[0], oled_mosi[0], oled_cs[0], oled_dc[0]);
        monitorStep(1, oled_sclk[1], oled_mosi[1], oled_cs[1], oled_dc[1]);
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rst"},   32'(oled_rst),  32'd0);
        checkOutput({tag, "_cs"},    32'(oled_cs),   32'd3);
        checkOutput({tag, "_dc"},    32'(oled_dc),   32'd0);
        checkOutput({tag, "_sclk"},  32'(oled_sclk), 32'(idle_sclk));
        checkOutput({tag, "_mosi"},  32'(oled_mosi), 32'd0);
        checkOutput({tag, "_ready"}, 32'(tx_ready),  32'd0);
        checkOutput({tag, "_init"},  32'(init_done), 32'd0);
        checkOutput({tag, "_busy"},  32'(busy),      32'd3);
    endtask

    // Called at a negedge with both instances freshly in RST_LOW.
    task automatic checkResetSequence(input string tag);
        int   n;
        logic quiet;
        quiet = 1'b1;
        n = 0;
        while (n < LIMIT) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (oled_cs !== 2'b11 || oled_sclk !== idle_sclk || tx_ready !== 2'b00 ||
                init_done !== 2'b00 || busy !== 2'b11) quiet = 1'b0;
            if (oled_rst[0] === 1'b1) break;
        end
        checkOutput({tag, "_rst_low_cycles"}, 32'(n), 32'(RST_CYCLES));
        checkOutput({tag, "_rst_pair"}, 32'(oled_rst), 32'd3);
        n = 0;
        while (n < LIMIT) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (oled_cs !== 2'b11 || oled_sclk !== idle_sclk || tx_ready !== init_done ||
                oled_rst !== 2'b11) quiet = 1'b0;
            if (init_done[0] === 1'b1) break;
        end
        checkOutput({tag, "_rst_wait_cycles"}, 32'(n), 32'(RST_WAIT));
        checkOutput({tag, "_init_pair"}, 32'(init_done), 32'd3);
        checkOutput({tag, "_ready_after_init"}, 32'(tx_ready), 32'd3);
        checkOutput({tag, "_pins_quiet"}, 32'(quiet), 32'd1);
    endtask

    // Offers one byte, records the expectation at the handshake, then follows the
    // frame timing until tx_ready returns. Leaves tx_valid high on return.
    task automatic applyStimulus(input logic [7:0] d, input logic dc, input logic last);
        int   waited;
        int   lat;
        exp_t e;
        tx_data  = d;
        tx_dc    = dc;
        tx_last  = last;
        tx_valid = 1'b1;
        waited = 0;
        while (tx_ready[0] !== 1'b1 && waited < LIMIT) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("accept_wait", 32'(waited < LIMIT), 32'd1);
        checkOutput("accept_ready_pair", 32'(tx_ready), 32'd3);
        e.data = d;
        e.dc   = dc;
        e.last = last;
        exp_q0.push_back(e);
        exp_q1.push_back(e);
        @(posedge clk);
        #1;
        checkOutput("start_cs",    32'(oled_cs),   32'd0);
        checkOutput("start_dc",    32'(oled_dc),   32'(dc ? 2'b11 : 2'b00));
        checkOutput("start_mosi",  32'(oled_mosi), 32'(d[7] ? 2'b11 : 2'b00));
        checkOutput("start_sclk",  32'(oled_sclk), 32'd0);
        checkOutput("start_ready", 32'(tx_ready),  32'd0);
        tx_data = ~d;
        tx_dc   = ~dc;
        tx_last = 1'($urandom_range(0, 1));
        lat = 0;
        while (lat < LIMIT) begin
            @(negedge clk);
            if (lat == BYTE_CYCLES - 1) begin
                checkOutput("shift_cs", 32'(oled_cs), 32'd0);
                checkOutput("shift_busy", 32'(busy), 32'd3);
            end
            if (lat == BYTE_CYCLES) begin
                checkOutput("end_cs", 32'(oled_cs), 32'(last ? 2'b11 : 2'b00));
                checkOutput("end_sclk", 32'(oled_sclk), 32'(idle_sclk));
            end
            if (tx_ready[0] === 1'b1) break;
            @(posedge clk);
            lat++;
        end
        checkOutput("ready_latency", 32'(lat), 32'(BYTE_CYCLES + (last ? CS_IDLE : 0)));
        checkOutput("ready_pair", 32'(tx_ready), 32'd3);
        checkOutput("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       rdc;
        logic       rlast;

        idle_sclk       = 2'b10;
        rst_n           = 1'b1;
        tx_valid        = 1'b0;
        tx_data         = 8'h00;
        tx_dc           = 1'b0;
        tx_last         = 1'b0;
        panel_reset_req = 1'b0;
        #1 rst_n = 1'b0;
        #1 checkResetValues("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkResetSequence("power_up");

        $display("[TB] single byte 0xA5, command, last");
        applyStimulus(8'hA5, 1'b0, 1'b1);

        $display("[TB] burst 0x00 0xFF 0x3C, data");
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        applyStimulus(8'h3C, 1'b1, 1'b1);

        $display("[TB] byte 0x81 on both clock modes");
        applyStimulus(8'h81, 1'b0, 1'b1);
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] panel reset request racing a byte offer");
        tx_data         = 8'h5A;
        tx_dc           = 1'b1;
        tx_last         = 1'b1;
        tx_valid        = 1'b1;
        panel_reset_req = 1'b1;
        #1 checkOutput("req_blocks_ready", 32'(tx_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        panel_reset_req = 1'b0;
        checkOutput("req_rst_low", 32'(oled_rst), 32'd0);
        checkOutput("req_init_low", 32'(init_done), 32'd0);
        checkResetSequence("panel_req");
        applyStimulus(8'h5A, 1'b1, 1'b1);

        $display("[TB] rst_n pulse in the middle of 0xC3");
        tx_data  = 8'hC3;
        tx_dc    = 1'b1;
        tx_last  = 1'b1;
        tx_valid = 1'b1;
        checkOutput("abort_accept_ready", 32'(tx_ready), 32'd3);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        repeat (7 * CLK_DIV) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetValues("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkResetSequence("after_abort");
        applyStimulus(8'hC3, 1'b1, 1'b1);

        $display("[TB] random stream");
        for (int i = 0; i < 40; i++) begin
            rd    = 8'($urandom);
            rdc   = 1'($urandom_range(0, 1));
            rlast = (i == 39) ? 1'b1 : 1'($urandom_range(0, 2) == 0);
            applyStimulus(rd, rdc, rlast);
            if ($urandom_range(0, 1) == 1) begin
                tx_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        tx_valid = 1'b0;

        repeat (4) @(negedge clk);
        checkOutput("drained_q0", 32'(exp_q0.size()), 32'd0);
        checkOutput("drained_q1", 32'(exp_q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
